// File: rtl/setting_adjuster_if.sv
`default_nettype none
// ============================================================================
// setting_adjuster_if : button/control inputs and value outputs of the adjuster
// Rev 1.0
// ============================================================================
interface setting_adjuster_if #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 2
) ();
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      enable;
  logic [CH_W-1:0]           ch_sel;
  logic                      inc_level;
  logic                      dec_level;
  logic                      load_default;
  logic [CHANNELS*WIDTH-1:0] values;
  logic                      step_pulse;
  logic                      limit_hit;

  modport master (
    output enable, ch_sel, inc_level, dec_level, load_default,
    input  values, step_pulse, limit_hit
  );

  modport slave (
    input  enable, ch_sel, inc_level, dec_level, load_default,
    output values, step_pulse, limit_hit
  );
endinterface
`default_nettype wire

// File: rtl/setting_adjuster.sv
`default_nettype none
// ============================================================================
// setting_adjuster : multi-channel bounded setting register with press/auto-repeat stepping
// Rev 1.0
// ============================================================================
module setting_adjuster #(
  parameter int WIDTH         = 6,
  parameter int CHANNELS      = 2,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 59,
  parameter int DEFAULT_VAL   = 5,
  parameter int WRAP          = 1,
  parameter int HOLD_DELAY    = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic              clk_100Hz,
  input  logic              rst,
  setting_adjuster_if.slave adj_if
);
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT_VAL);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             inc_prev_q, dec_prev_q;
  logic             step_pulse_q, step_pulse_d;
  logic             limit_hit_q, limit_hit_d;
  logic [WIDTH-1:0] vals_q [CHANNELS];
  logic [WIDTH-1:0] vals_d [CHANNELS];

  logic             rise_inc, rise_dec;
  logic             ch_ok, load_req, hold_ok;
  logic             step_req, step_dir;
  logic [CH_W-1:0]  step_ch, wr_ch;
  logic [WIDTH-1:0] cur_val, nxt_val;
  logic             wr_en;

  assign rise_inc = adj_if.inc_level & ~inc_prev_q;
  assign rise_dec = adj_if.dec_level & ~dec_prev_q;
  assign ch_ok    = (int'(adj_if.ch_sel) < CHANNELS);
  assign load_req = adj_if.enable & adj_if.load_default & ch_ok;
  // A hold survives only while its own button is the sole one pressed.
  assign hold_ok  = adj_if.enable & (dir_q ? (adj_if.inc_level & ~adj_if.dec_level)
                                           : (adj_if.dec_level & ~adj_if.inc_level));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    ch_d     = ch_q;
    step_req = 1'b0;
    step_dir = dir_q;
    step_ch  = ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (adj_if.enable && ch_ok && (rise_inc ^ rise_dec)) begin
          step_req = 1'b1;
          step_dir = rise_inc;
          step_ch  = adj_if.ch_sel;
          dir_d    = rise_inc;
          ch_d     = adj_if.ch_sel;
          cnt_d    = '0;
          state_d  = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!hold_ok) begin
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          step_req = 1'b1;
          cnt_d    = '0;
          state_d  = S_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!hold_ok) begin
          state_d = S_IDLE;
        end else if (cnt_q == REP_LAST) begin
          step_req = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_req) begin
      step_req = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_comb begin
    wr_ch        = load_req ? adj_if.ch_sel : step_ch;
    cur_val      = DEF_V;
    nxt_val      = DEF_V;
    wr_en        = 1'b0;
    limit_hit_d  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      vals_d[i] = vals_q[i];
      if (int'(wr_ch) == i) cur_val = vals_q[i];
    end
    nxt_val = cur_val;
    if (load_req) begin
      nxt_val = DEF_V;
      wr_en   = (cur_val != DEF_V);
    end else if (step_req) begin
      if (step_dir) begin
        if (cur_val == MAX_V) begin
          if (WRAP != 0) begin
            nxt_val = MIN_V;
            wr_en   = 1'b1;
          end else begin
            limit_hit_d = 1'b1;
          end
        end else begin
          nxt_val = cur_val + WIDTH'(1);
          wr_en   = 1'b1;
        end
      end else begin
        if (cur_val == MIN_V) begin
          if (WRAP != 0) begin
            nxt_val = MAX_V;
            wr_en   = 1'b1;
          end else begin
            limit_hit_d = 1'b1;
          end
        end else begin
          nxt_val = cur_val - WIDTH'(1);
          wr_en   = 1'b1;
        end
      end
    end
    step_pulse_d = wr_en;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en && (int'(wr_ch) == i)) vals_d[i] = nxt_val;
    end
  end

  // Previous levels reset high so a button held through reset must be re-pressed.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      ch_q         <= '0;
      inc_prev_q   <= 1'b1;
      dec_prev_q   <= 1'b1;
      step_pulse_q <= 1'b0;
      limit_hit_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) vals_q[i] <= DEF_V;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      ch_q         <= ch_d;
      inc_prev_q   <= adj_if.inc_level;
      dec_prev_q   <= adj_if.dec_level;
      step_pulse_q <= step_pulse_d;
      limit_hit_q  <= limit_hit_d;
      for (int i = 0; i < CHANNELS; i++) vals_q[i] <= vals_d[i];
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign adj_if.values[g*WIDTH +: WIDTH] = vals_q[g];
    end
  endgenerate

  assign adj_if.step_pulse = step_pulse_q;
  assign adj_if.limit_hit  = limit_hit_q;
endmodule
`default_nettype wire

// File: tb/tb_setting_adjuster.sv
`default_nettype none
// ============================================================================
// tb_setting_adjuster : wrapping and saturating instances driven in lockstep against a cycle model
// Rev 1.0
// ============================================================================
module tb_setting_adjuster;
  localparam int WIDTH = 6, CHANNELS = 2, MIN_VAL = 0, MAX_VAL = 59, DEFAULT_VAL = 5;
  localparam int HOLD_DELAY = 50, REPEAT_PERIOD = 10;
  localparam int VW = CHANNELS * WIDTH;

  logic clk_100Hz = 1'b0;
  logic rst       = 1'b1;
  always #5 clk_100Hz = ~clk_100Hz;

  setting_adjuster_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bw ();
  setting_adjuster_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bs ();

  assign bs.enable       = bw.enable;
  assign bs.ch_sel       = bw.ch_sel;
  assign bs.inc_level    = bw.inc_level;
  assign bs.dec_level    = bw.dec_level;
  assign bs.load_default = bw.load_default;

  setting_adjuster #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .DEFAULT_VAL(DEFAULT_VAL), .WRAP(1), .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_wrap (.clk_100Hz(clk_100Hz), .rst(rst), .adj_if(bw.slave));

  setting_adjuster #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .DEFAULT_VAL(DEFAULT_VAL), .WRAP(0), .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_sat (.clk_100Hz(clk_100Hz), .rst(rst), .adj_if(bs.slave));

  int tests = 0;
  int fails = 0;

  // Model: instance 0 wraps, instance 1 saturates; a hold is tracked by its age in cycles.
  int mv [2][CHANNELS];
  bit mp [2];
  bit ml [2];
  bit m_active, m_dir, m_pi, m_pd;
  int m_age, m_ch;

  function automatic void m_step();
    for (int k = 0; k < 2; k++) begin
      int v = mv[k][m_ch];
      if (m_dir) begin
        if (v == MAX_VAL) begin
          if (k == 0) begin v = MIN_VAL; mp[k] = 1'b1; end
          else ml[k] = 1'b1;
        end else begin v = v + 1; mp[k] = 1'b1; end
      end else begin
        if (v == MIN_VAL) begin
          if (k == 0) begin v = MAX_VAL; mp[k] = 1'b1; end
          else ml[k] = 1'b1;
        end else begin v = v - 1; mp[k] = 1'b1; end
      end
      mv[k][m_ch] = v;
    end
  endfunction

  function automatic void model_update();
    bit en, inc, dec, ld, ri, rd, held;
    int sel;
    en = bw.enable; inc = bw.inc_level; dec = bw.dec_level; ld = bw.load_default;
    sel = int'(bw.ch_sel);
    for (int k = 0; k < 2; k++) begin mp[k] = 1'b0; ml[k] = 1'b0; end
    if (rst) begin
      for (int k = 0; k < 2; k++) for (int c = 0; c < CHANNELS; c++) mv[k][c] = DEFAULT_VAL;
      m_pi = 1'b1; m_pd = 1'b1; m_active = 1'b0;
      return;
    end
    ri = inc && !m_pi;
    rd = dec && !m_pd;
    if (en && ld && sel < CHANNELS) begin
      for (int k = 0; k < 2; k++) begin
        mp[k] = (mv[k][sel] != DEFAULT_VAL);
        mv[k][sel] = DEFAULT_VAL;
      end
      m_active = 1'b0;
    end else if (m_active) begin
      held = en && (m_dir ? (inc && !dec) : (dec && !inc));
      if (!held) m_active = 1'b0;
      else begin
        m_age++;
        if (m_age == HOLD_DELAY ||
            (m_age > HOLD_DELAY && (m_age - HOLD_DELAY) % REPEAT_PERIOD == 0)) m_step();
      end
    end else if (en && sel < CHANNELS && (ri != rd)) begin
      m_active = 1'b1; m_age = 0; m_dir = ri; m_ch = sel;
      m_step();
    end
    m_pi = inc; m_pd = dec;
  endfunction

  function automatic logic [VW-1:0] m_pack(int k);
    logic [VW-1:0] r = '0;
    for (int c = 0; c < CHANNELS; c++) r[c*WIDTH +: WIDTH] = WIDTH'(mv[k][c]);
    return r;
  endfunction

  task automatic drive(bit en, int sel, bit inc, bit dec, bit ld);
    bw.enable = en; bw.ch_sel = 1'(sel); bw.inc_level = inc; bw.dec_level = dec;
    bw.load_default = ld;
  endtask

  task automatic tick();
    @(posedge clk_100Hz);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tests++; if (bw.values !== {6'd5, 6'd5}) begin fails++; $display("FAIL reset_values_wrap got=%h exp=%h", bw.values, {6'd5, 6'd5}); end
    tests++; if (bs.values !== {6'd5, 6'd5}) begin fails++; $display("FAIL reset_values_sat got=%h exp=%h", bs.values, {6'd5, 6'd5}); end
    tests++; if (bw.step_pulse !== 1'b0 || bw.limit_hit !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", bw.step_pulse, bw.limit_hit); end
    tick();
  endtask

  task automatic test_single_step();
    int pulses = 0;
    drive(1, 0, 1, 0, 0); tick();
    if (bw.step_pulse === 1'b1) pulses++;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin tick(); if (bw.step_pulse === 1'b1) pulses++; end
    tests++; if (bw.values !== {6'd5, 6'd6}) begin fails++; $display("FAIL single_step_values got=%h exp=%h", bw.values, {6'd5, 6'd6}); end
    tests++; if (pulses != 1) begin fails++; $display("FAIL single_step_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_wrap();
    int guard = 0;
    drive(1, 0, 1, 0, 0);
    while (mv[0][0] != MAX_VAL && guard < 1000) begin
      tick(); guard++;
      tests++; if (bw.values !== m_pack(0)) begin fails++; $display("FAIL ramp_values cyc=%0d got=%h exp=%h", guard, bw.values, m_pack(0)); end
    end
    tests++; if (guard >= 1000) begin fails++; $display("FAIL ramp_timeout got=%0d exp=<1000", guard); end
    drive(1, 0, 0, 0, 0); tick();
    tests++; if (bs.values !== {6'd5, 6'd59}) begin fails++; $display("FAIL ramp_sat got=%h exp=%h", bs.values, {6'd5, 6'd59}); end
    drive(1, 0, 1, 0, 0); tick();
    tests++; if (bw.values !== {6'd5, 6'd0} || bw.step_pulse !== 1'b1) begin fails++; $display("FAIL wrap_inc got=%h/%b exp=%h/1", bw.values, bw.step_pulse, {6'd5, 6'd0}); end
    tests++; if (bs.values !== {6'd5, 6'd59} || bs.limit_hit !== 1'b1 || bs.step_pulse !== 1'b0) begin fails++; $display("FAIL sat_inc got=%h/lim%b/pulse%b exp=%h/lim1/pulse0", bs.values, bs.limit_hit, bs.step_pulse, {6'd5, 6'd59}); end
    drive(1, 0, 0, 0, 0); tick();
    tests++; if (bs.limit_hit !== 1'b0) begin fails++; $display("FAIL sat_limit_one_cycle got=%b exp=0", bs.limit_hit); end
    drive(1, 0, 0, 1, 0); tick();
    tests++; if (bw.values !== {6'd5, 6'd59} || bw.step_pulse !== 1'b1) begin fails++; $display("FAIL wrap_dec got=%h/%b exp=%h/1", bw.values, bw.step_pulse, {6'd5, 6'd59}); end
    tests++; if (bs.values !== {6'd5, 6'd58}) begin fails++; $display("FAIL sat_dec got=%h exp=%h", bs.values, {6'd5, 6'd58}); end
    drive(1, 0, 0, 0, 0); tick();
  endtask

  task automatic test_hold();
    int pulses = 0;
    bit exp_p;
    drive(1, 0, 0, 0, 1); tick();
    tests++; if (bw.values !== {6'd5, 6'd5} || bw.step_pulse !== 1'b1 || bs.step_pulse !== 1'b1) begin fails++; $display("FAIL load_ch0 got=%h/%b%b exp=%h/11", bw.values, bw.step_pulse, bs.step_pulse, {6'd5, 6'd5}); end
    drive(1, 0, 0, 0, 0); tick();
    for (int k = 0; k <= 80; k++) begin
      drive(1, (k >= 30) ? 1 : 0, 1, 0, 0);
      tick();
      exp_p = (k == 0 || k == 50 || k == 60 || k == 70 || k == 80);
      if (bw.step_pulse === 1'b1) pulses++;
      tests++; if (bw.step_pulse !== exp_p) begin fails++; $display("FAIL hold_pulse k=%0d got=%b exp=%b", k, bw.step_pulse, exp_p); end
    end
    drive(1, 1, 0, 0, 0); tick();
    tests++; if (bw.values !== {6'd5, 6'd10} || bs.values !== {6'd5, 6'd10}) begin fails++; $display("FAIL hold_values got=%h/%h exp=%h", bw.values, bs.values, {6'd5, 6'd10}); end
    tests++; if (pulses != 5) begin fails++; $display("FAIL hold_pulse_count got=%0d exp=5", pulses); end
  endtask

  task automatic test_conflict_load();
    int guard = 0;
    int pulses = 0;
    drive(1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin tick(); if (bw.step_pulse === 1'b1) pulses++; end
    tests++; if (bw.values !== {6'd5, 6'd10} || pulses != 0) begin fails++; $display("FAIL both_rise got=%h/%0d exp=%h/0", bw.values, pulses, {6'd5, 6'd10}); end
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); if (bw.step_pulse === 1'b1) pulses++; end
    drive(1, 0, 1, 0, 0); tick();
    if (bw.step_pulse === 1'b1) pulses++;
    tests++; if (bw.values !== {6'd5, 6'd10} || pulses != 0) begin fails++; $display("FAIL disabled_press got=%h/%0d exp=%h/0", bw.values, pulses, {6'd5, 6'd10}); end
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0);
    while (mv[0][1] != 20 && guard < 500) begin tick(); guard++; end
    tests++; if (guard >= 500) begin fails++; $display("FAIL ch1_ramp_timeout got=%0d exp=<500", guard); end
    drive(1, 1, 0, 0, 0); tick();
    tests++; if (bw.values !== {6'd20, 6'd10}) begin fails++; $display("FAIL ch1_ramp got=%h exp=%h", bw.values, {6'd20, 6'd10}); end
    drive(1, 1, 0, 0, 1); tick();
    tests++; if (bw.values !== {6'd5, 6'd10} || bw.step_pulse !== 1'b1) begin fails++; $display("FAIL load_ch1 got=%h/%b exp=%h/1", bw.values, bw.step_pulse, {6'd5, 6'd10}); end
    tick();
    tests++; if (bw.step_pulse !== 1'b0) begin fails++; $display("FAIL load_same_no_pulse got=%b exp=0", bw.step_pulse); end
    drive(1, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_mid_hold();
    int pulses = 0;
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 65; i++) tick();
    tests++; if (bw.values !== {6'd5, 6'd13}) begin fails++; $display("FAIL pre_reset_hold got=%h exp=%h", bw.values, {6'd5, 6'd13}); end
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (bw.step_pulse === 1'b1) pulses++; end
    tests++; if (bw.values !== {6'd5, 6'd5} || pulses != 0) begin fails++; $display("FAIL reset_hold got=%h/%0d exp=%h/0", bw.values, pulses, {6'd5, 6'd5}); end
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0); tick();
    tests++; if (bw.values !== {6'd5, 6'd6} || bw.step_pulse !== 1'b1) begin fails++; $display("FAIL repress got=%h/%b exp=%h/1", bw.values, bw.step_pulse, {6'd5, 6'd6}); end
    drive(1, 0, 0, 0, 0); tick();
    tests++; if (bw.step_pulse !== 1'b0 || bw.values !== {6'd5, 6'd6}) begin fails++; $display("FAIL repress_single got=%h/%b exp=%h/0", bw.values, bw.step_pulse, {6'd5, 6'd6}); end
  endtask

  task automatic test_random();
    bit en = 1'b1, inc = 1'b0, dec = 1'b0;
    int sel = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) inc = !inc;
      if ($urandom_range(39) == 0) dec = !dec;
      if (en ? ($urandom_range(149) == 0) : ($urandom_range(9) == 0)) en = !en;
      if ($urandom_range(29) == 0) sel = int'($urandom_range(CHANNELS - 1));
      rst = ($urandom_range(499) == 0);
      drive(en, sel, inc, dec, $urandom_range(63) == 0);
      tick();
      tests++; if (bw.values !== m_pack(0)) begin fails++; $display("FAIL rand_values_wrap cyc=%0d got=%h exp=%h", c, bw.values, m_pack(0)); end
      tests++; if (bs.values !== m_pack(1)) begin fails++; $display("FAIL rand_values_sat cyc=%0d got=%h exp=%h", c, bs.values, m_pack(1)); end
      tests++; if (bw.step_pulse !== mp[0] || bs.step_pulse !== mp[1]) begin fails++; $display("FAIL rand_pulse cyc=%0d got=%b%b exp=%b%b", c, bw.step_pulse, bs.step_pulse, mp[0], mp[1]); end
      tests++; if (bw.limit_hit !== ml[0] || bs.limit_hit !== ml[1]) begin fails++; $display("FAIL rand_limit cyc=%0d got=%b%b exp=%b%b", c, bw.limit_hit, bs.limit_hit, ml[0], ml[1]); end
    end
    rst = 1'b0;
    drive(1, 0, 0, 0, 0); tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_single_step();
    test_wrap();
    test_hold();
    test_conflict_load();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
